// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and control states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SRL = 3'b100,
        ALU_XOR = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_e;

    typedef enum logic {
        StIdle,
        StMul
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand-read stage, the ALU and writeback.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle; fixed latency.
module alu_mul_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int unsigned MUL_ITERS = WIDTH / MUL_BITS;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS + 1);

    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [WIDTH-1:0] pp, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
        end
        acc_sum  = acc_q + pp;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = CNT_W'(MUL_ITERS);
        end else if (cnt_q != '0) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    // Final step: the sum formed this cycle is the full product.
    assign done_o    = (cnt_q == CNT_W'(1));
    assign product_o = acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops in 1 cycle, MUL iterative.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_res, mul_product;
    logic [SHAMT_W-1:0] shamt;
    logic             in_ready, accept, is_mul, mul_start, mul_done;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = (alu_op_e'(bus.op) == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign shamt     = bus.b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        unique case (alu_op_e'(bus.op))
            ALU_ADD: alu_res = bus.a + bus.b;
            ALU_SUB: alu_res = bus.a - bus.b;
            ALU_MUL: alu_res = '0;
            ALU_SLL: alu_res = bus.a << shamt;
            ALU_SRL: alu_res = bus.a >> shamt;
            ALU_XOR: alu_res = bus.a ^ bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_AND: alu_res = bus.a & bus.b;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (state_q == StIdle) begin
            if (mul_start) begin
                state_d = StMul;
            end else if (accept) begin
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                out_valid_d = 1'b1;
            end
        end else if (mul_done) begin
            state_d     = StIdle;
            result_d    = mul_product;
            zero_d      = (mul_product == '0);
            out_valid_d = 1'b1;
        end
    end

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = (state_q == StMul);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard queue of expected results, one task per scenario.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passed = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_v;

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(32)) bus4 ();

    alu_seq #(.WIDTH(32), .MUL_BITS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_seq #(.WIDTH(32), .MUL_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b0 ||
            bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL reset: got v=%b r=%h z=%b busy=%b rdy=%b required 0 0 0 0 1",
                     bus.out_valid, bus.result, bus.zero, bus.busy, bus.in_ready);
        end else passed++;
    endtask

    task automatic test_add_sub();
        drive(ALU_ADD, 32'd5, 32'd7);
        sb.push_back(32'd12);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp_v || bus.zero !== 1'b0) begin
            $display("FAIL add: got v=%b r=%h z=%b required 1 %h 0",
                     bus.out_valid, bus.result, bus.zero, exp_v);
        end else passed++;
        drive(ALU_SUB, 32'd3, 32'd3);
        sb.push_back(32'd0);
        tick();
        bus.in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp_v || bus.zero !== 1'b1) begin
            $display("FAIL sub_zero: got v=%b r=%h z=%b required 1 %h 1",
                     bus.out_valid, bus.result, bus.zero, exp_v);
        end else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL drain: got v=%b required 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_mul();
        int  n;
        bit  busy_ok;
        drive(ALU_MUL, 32'hFFFF_FFFF, 32'd2);
        sb.push_back(32'hFFFF_FFFE);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            n++;
        end
        checks++;
        if (n !== 32) $display("FAIL mul_latency: got %0d edges required 32", n);
        else passed++;
        checks++;
        if (!busy_ok) $display("FAIL mul_busy: got busy/in_ready wrong while iterating");
        else passed++;
        exp_v = sb.pop_front();
        checks++;
        if (bus.result !== exp_v || bus.busy !== 1'b0 || bus.zero !== 1'b0) begin
            $display("FAIL mul_result: got r=%h busy=%b z=%b required %h 0 0",
                     bus.result, bus.busy, bus.zero, exp_v);
        end else passed++;
        tick();
        // Same product through the 4-bits-per-step instance.
        bus4.in_valid = 1'b1;
        bus4.op       = ALU_MUL;
        bus4.a        = 32'hFFFF_FFFF;
        bus4.b        = 32'd2;
        sb.push_back(32'hFFFF_FFFE);
        tick();
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8) $display("FAIL mul4_latency: got %0d edges required 8", n);
        else passed++;
        exp_v = sb.pop_front();
        checks++;
        if (bus4.result !== exp_v) $display("FAIL mul4_result: got %h required %h", bus4.result, exp_v);
        else passed++;
        tick();
    endtask

    task automatic test_shifts();
        drive(ALU_SLL, 32'd1, 32'd33);
        sb.push_back(32'd2);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if (bus.result !== exp_v) $display("FAIL sll: got %h required %h", bus.result, exp_v);
        else passed++;
        drive(ALU_SRL, 32'h8000_0000, 32'd31);
        sb.push_back(32'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (bus.result !== exp_v) $display("FAIL srl: got %h required %h", bus.result, exp_v);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        bit hold_ok;
        bus.out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1);
        sb.push_back(32'd2);
        tick();
        drive(ALU_OR, 32'd3, 32'd4);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.in_ready !== 1'b0)
                hold_ok = 1'b0;
            tick();
        end
        checks++;
        if (!hold_ok) $display("FAIL bp_hold: got result/in_ready not held (r=%h)", bus.result);
        else passed++;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_ready: got in_ready=%b required 1", bus.in_ready);
        else passed++;
        exp_v = sb.pop_front();
        checks++;
        if (bus.result !== exp_v) $display("FAIL bp_result: got %h required %h", bus.result, exp_v);
        else passed++;
        sb.push_back(32'd7);
        tick();
        bus.in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp_v) begin
            $display("FAIL bp_next: got v=%b r=%h required 1 %h", bus.out_valid, bus.result, exp_v);
        end else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        bit rdy_ok;
        int bad;
        rdy_ok = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = $urandom;
            drive(ALU_XOR, x, y);
            sb.push_back(x ^ y);
            #1;
            if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
            exp_v = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.result !== exp_v) begin
                bad++;
                $display("FAIL b2b_%0d: got v=%b r=%h required 1 %h", i, bus.out_valid,
                         bus.result, exp_v);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL b2b_results: got %0d wrong required 0", bad);
        else passed++;
        checks++;
        if (!rdy_ok) $display("FAIL b2b_ready: got in_ready low during stream required high");
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int spurious;
        drive(ALU_MUL, 32'd1000, 32'd1000);
        sb.push_back(32'd1_000_000);
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL rst_pre_busy: got %b required 1", bus.busy);
        else passed++;
        rst_n = 1'b0;
        void'(sb.pop_front());
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0) begin
            $display("FAIL rst_mid_mul: got v=%b busy=%b r=%h required 0 0 0",
                     bus.out_valid, bus.busy, bus.result);
        end else passed++;
        #1;
        rst_n = 1'b1;
        tick();
        drive(ALU_ADD, 32'd2, 32'd2);
        sb.push_back(32'd4);
        tick();
        bus.in_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp_v) begin
            $display("FAIL rst_add: got v=%b r=%h required 1 %h", bus.out_valid, bus.result, exp_v);
        end else passed++;
        spurious = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) $display("FAIL rst_spurious: got %0d cycles with output required 0", spurious);
        else passed++;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.op         = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.op        = '0;
        bus4.out_ready = 1'b1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_add_sub();
        test_mul();
        test_shifts();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d left required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Same 3-bit op encoding. MUL (op 010) is now implemented with an iterative shift-add multiplier instead of returning a poison value.
- Valid/ready handshake on both sides, so it can sit between the decode/operand-read stage and writeback.
- Single-cycle ops have 1-cycle latency. MUL has fixed latency of WIDTH/MUL_BITS cycles.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, ≥ 8.
- MUL_BITS, 1: multiplier bits retired per MUL iteration; must divide WIDTH (1, 2, 4 supported).
- Derived localparams:
  - SHAMT_W = $clog2(WIDTH)
  - MUL_ITERS = WIDTH/MUL_BITS

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  ADD=000 SUB=001 MUL=010 SLL=011 SRL=100 XOR=101 OR=110 AND=111
- out_valid  out  1  result/zero valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0); meaningful only while out_valid
- busy  out  1  high while a MUL is iterating

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; out_valid=0, result=0, zero=0, busy=0.
  - MUL accumulator, counter and operand shadows cleared.
- States:
  - IDLE: accepting operations.
  - MUL: iterating.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from out_ready; no other input paths.
- Accept = in_valid && in_ready, sampled at rising edge t.
- Non-MUL accepted at edge t:
  - At edge t, result and zero are loaded and out_valid=1; visible in cycle t+1 (latency 1).
  - Back-to-back acceptance gives 1 op/cycle while out_ready=1.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry/overflow outputs.
  - SLL/SRL are logical and use b[SHAMT_W-1:0] only; upper bits of b are ignored.
  - XOR/OR/AND are bitwise.
- MUL accepted at edge t:
  - At edge t: state→MUL, busy=1, acc=0, mcand=a, mplier=b, cnt=MUL_ITERS. If out_valid was set and out_ready=1, out_valid clears at edge t.
  - At each edge t+1..t+MUL_ITERS: acc += mcand * mplier[MUL_BITS-1:0] (low WIDTH bits kept), mcand <<= MUL_BITS, mplier >>= MUL_BITS, cnt--.
  - At the edge where cnt==1: result = final acc, zero updated, out_valid=1, busy=0, state→IDLE.
  - Latency is exactly MUL_ITERS edges, with no early termination even if b==0.
  - Result is the low WIDTH bits of the unsigned product (equal to the signed low half).
- Output hold:
  - While out_valid && !out_ready, result and zero stay stable and in_ready=0.
  - out_valid clears at the edge where out_ready=1 unless a new op completes at the same edge.
- Simultaneous drain + accept: the old result is consumed and the new single-cycle result is loaded at the same edge; out_valid stays 1.
- In MUL state, in_valid is ignored (in_ready=0). Operands need not be held by the producer after acceptance.
- Reset mid-MUL: the operation is abandoned; all outputs return to reset values immediately; no stale result is ever presented.
- op values are exhaustive; no default/poison path.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding enum/localparams: ALU_ADD..ALU_AND, with ALU_MUL=3'b010.
  - state encoding: IDLE, MUL.
- One natural sub-module: alu_mul_iter. It owns acc/mcand/mplier/cnt with start/done pulses. The top keeps the handshake, the single-cycle datapath and the output register.

Test Plan:
1. ADD a=5 b=7 with out_ready=1 → result=12, zero=0, out_valid one cycle after accept; SUB a=3 b=3 → result=0, zero=1.
2. MUL a=0xFFFFFFFF b=2 (WIDTH=32, MUL_BITS=1) → busy=1 for 32 cycles, then result=0xFFFFFFFE, out_valid exactly 32 edges after accept; repeat with MUL_BITS=4 → 8 edges.
3. SLL a=1 b=33 → result=2 (shift by 1); SRL a=0x80000000 b=31 → result=1.
4. Backpressure: complete ADD 1+1 with out_ready=0 for 5 cycles → result held at 2, in_ready=0 throughout, then out_ready=1 → single transfer, next op accepted at the same edge.
5. Stream 8 back-to-back XOR ops with out_ready=1 → in_ready stays high, 8 results on consecutive cycles in order.
6. Assert rst_n=0 on the 10th MUL iteration of 1000*1000 → out_valid=0, busy=0, result=0 immediately; after release, ADD 2+2 → 4 with no spurious MUL result.
